// File: rtl/slt_search.sv
// Successive-approximation recovery of a hidden signed value through an external signed less-than comparator.
// Optional build macro SLT_SEARCH_TIMEOUT_EN adds a response watchdog that drives the sticky error flag.
module slt_search #(
  parameter int N       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic signed [N-1:0] probe,
  output logic                probe_valid,
  input  logic                resp_valid,
  input  logic                lt,
  output logic signed [N-1:0] result,
  output logic                done,
  output logic                busy,
  output logic                error
);

  localparam int              IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);
  localparam logic [N-1:0]    SIGN_BIT = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     acc, acc_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [N-1:0]     bit_sel;
  logic [N-1:0]     trial;
  logic             load_res;

  // Offset-binary <-> two's complement differ only in the sign bit.
  function automatic logic [N-1:0] flip_sign(input logic [N-1:0] v);
    return v ^ SIGN_BIT;
  endfunction

  assign bit_sel = {{(N-1){1'b0}}, 1'b1} << idx;
  assign trial   = acc | bit_sel;

`ifdef SLT_SEARCH_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_fire;
  logic             err_q;

  // Counts consecutive waiting cycles; fires on the TIMEOUT-th one.
  assign tmo_fire = (state == PROBE) && !resp_valid && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state != PROBE || resp_valid)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
      if (state == IDLE && start)
        err_q <= 1'b0;
      else if (tmo_fire)
        err_q <= 1'b1;
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    idx_nxt   = idx;
    load_res  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = PROBE;
          acc_nxt   = '0;
          idx_nxt   = IDX_TOP;
        end
      end
      PROBE: begin
        if (resp_valid) begin
          acc_nxt = lt ? acc : trial;
          if (idx == '0) begin
            state_nxt = DONE;
            load_res  = 1'b1;
          end else begin
            idx_nxt = idx - 1'b1;
          end
        end
`ifdef SLT_SEARCH_TIMEOUT_EN
        else if (tmo_fire) begin
          state_nxt = IDLE;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      idx    <= IDX_TOP;
      result <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      idx   <= idx_nxt;
      if (load_res)
        result <= $signed(flip_sign(acc_nxt));
    end
  end

  assign probe_valid = (state == PROBE);
  assign probe       = probe_valid ? $signed(flip_sign(trial)) : '0;
  assign done        = (state == DONE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_slt_search.sv
// Bench for slt_search (N=8): behavioural signed comparator, probe-sequence model and directed searches.
module tb_slt_search;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        probe_w;
  logic              probe_valid;
  logic              resp_valid = 1'b0;
  logic              lt;
  logic [7:0]        result_w;
  logic              done, busy, error;

  logic signed [7:0] target = 8'sd0;
  int                rmode = 0;
  int                wcnt = 2;
  int                k = 0;
  int                done_cnt = 0;
  int                checks = 0;
  int                errors = 0;
  bit                mon_en = 1'b0;
  logic [7:0]        last_result = 8'h00;
  logic [7:0]        prev_probe = 8'h00;
  bit                prev_wait = 1'b0;
  logic [7:0]        plog [16];
  int                plen = 0;

  slt_search #(.N(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .probe(probe_w), .probe_valid(probe_valid),
    .resp_valid(resp_valid), .lt(lt), .result(result_w), .done(done), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Behavioural comparator: target strictly below probe, signed.
  assign lt = resp_valid && (target < $signed(probe_w));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Probe k of a search = the top k offset-binary bits of the target, then a trial 1, back to two's complement.
  function automatic logic [7:0] exp_probe(input logic signed [7:0] t, input int kk);
    logic [7:0] ob, mask, one;
    ob   = t ^ 8'h80;
    mask = 8'hFF << (8 - kk);
    one  = 8'h80 >> kk;
    return ((ob & mask) | one) ^ 8'h80;
  endfunction

  // Responder: 0 = always ready, 1 = random 0-3 wait cycles per probe, 3 = silent after two responses.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: resp_valid = 1'b1;
      1: begin
        if (probe_valid && wcnt == 0) begin
          resp_valid = 1'b1;
          wcnt = $urandom_range(0, 3);
        end else begin
          resp_valid = 1'b0;
          if (probe_valid && wcnt > 0) wcnt--;
        end
      end
      3: resp_valid = (k < 2);
      default: resp_valid = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (probe_valid) begin
        chk("probe_seq", {24'b0, probe_w}, {24'b0, exp_probe(target, k)});
        chk("busy_in_probe", {31'b0, busy}, 32'd1);
        if (prev_wait) chk("probe_stable", {24'b0, probe_w}, {24'b0, prev_probe});
        if (resp_valid && plen < 16) begin
          plog[plen] = probe_w;
          plen++;
        end
      end else begin
        chk("probe_idle_zero", {24'b0, probe_w}, 32'd0);
      end
      if (done) begin
        chk("done_result", {24'b0, result_w}, {24'b0, $unsigned(target)});
        done_cnt++;
      end else begin
        chk("result_hold", {24'b0, result_w}, {24'b0, last_result});
      end
`ifndef SLT_SEARCH_TIMEOUT_EN
      chk("error_low", {31'b0, error}, 32'd0);
`endif
      prev_wait  = probe_valid && !resp_valid && !rst;
      prev_probe = probe_w;
      if (done) last_result = $unsigned(target);
      if (rst) last_result = 8'h00;
      if (rst || done) k = 0;
      else if (probe_valid && resp_valid) k++;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_search(input logic signed [7:0] t, input int mode, input bit extra, output int lat);
    int d0;
    bit got;
    target = t; rmode = mode; wcnt = 2; plen = 0; d0 = done_cnt; lat = 0; got = 1'b0;
    pulse_start();
    for (int c = 1; c <= 200 && !got; c++) begin
      @(negedge clk);
      if (extra) start = (c == 3 || c == 6);
      if (done) begin got = 1'b1; lat = c; end
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("done_count", done_cnt - d0, 32'd1);
    chk("result_final", {24'b0, result_w}, {24'b0, $unsigned(t)});
    chk("busy_after", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int lat, c, d0;
    logic [7:0] exp32 [8];
    logic [7:0] res_before;
    exp32 = '{8'h00, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFD};

    // Reset with start and a response present: both must be ignored.
    start = 1'b1; rmode = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_probe", {24'b0, probe_w}, 32'd0);
    chk("rst_probe_valid", {31'b0, probe_valid}, 32'd0);
    chk("rst_result", {24'b0, result_w}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    mon_en = 1'b1;

    // Target -3 with responses always ready: literal probe trace and latency.
    run_search(-8'sd3, 0, 1'b0, lat);
    chk("t_m3_latency", lat, 32'd9);
    chk("t_m3_nprobes", plen, 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("t_m3_probe%0d", i), {24'b0, plog[i]}, {24'b0, exp32[i]});
    chk("t_m3_result", {24'b0, result_w}, 32'h0000_00FD);

    // Boundaries.
    run_search(-8'sd128, 0, 1'b0, lat);
    chk("t_min_result", {24'b0, result_w}, 32'h0000_0080);
    run_search(8'sd127, 0, 1'b0, lat);
    chk("t_max_result", {24'b0, result_w}, 32'h0000_007F);

    // Start held high: restart happens two cycles after done.
    target = -8'sd3; rmode = 0; d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    for (c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 9)  chk("b2b_done", {31'b0, done}, 32'd1);
      if (c == 10) chk("b2b_idle_gap", {31'b0, probe_valid}, 32'd0);
      if (c == 11) chk("b2b_restart", {31'b0, probe_valid}, 32'd1);
    end
    start = 1'b0;
    for (c = 0; c < 40 && done_cnt - d0 < 2; c++) @(negedge clk);
    chk("b2b_done_count", done_cnt - d0, 32'd2);
    @(negedge clk);

    // Random wait cycles from the responder.
    run_search(8'sd37, 1, 1'b0, lat);
    chk("t_25_result", {24'b0, result_w}, 32'h0000_0025);
    chk("t_25_waits_seen", {31'b0, (lat >= 9)}, 32'd1);
    run_search(-8'sd77, 1, 1'b0, lat);

    // Reset on the fourth probe, then a fresh search with ignored extra starts.
    target = 8'sh5A; rmode = 0;
    pulse_start();
    for (c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (probe_valid && k == 3) break;
    end
    chk("rst4_reached", {31'b0, (c < 20)}, 32'd1);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst4_probe", {24'b0, probe_w}, 32'd0);
    chk("rst4_probe_valid", {31'b0, probe_valid}, 32'd0);
    chk("rst4_result", {24'b0, result_w}, 32'd0);
    chk("rst4_done", {31'b0, done}, 32'd0);
    chk("rst4_busy", {31'b0, busy}, 32'd0);
    chk("rst4_error", {31'b0, error}, 32'd0);
    run_search(8'sh11, 0, 1'b1, lat);
    chk("t_11_result", {24'b0, result_w}, 32'h0000_0011);
    chk("t_11_latency", lat, 32'd9);

    // Responder goes silent after the second probe.
    target = 8'sh40; rmode = 3; d0 = done_cnt; res_before = result_w;
    pulse_start();
    for (c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
`ifdef SLT_SEARCH_TIMEOUT_EN
    chk("tmo_cycle", c, 32'd19);
    chk("tmo_error", {31'b0, error}, 32'd1);
    chk("tmo_busy", {31'b0, busy}, 32'd0);
    chk("tmo_probe_valid", {31'b0, probe_valid}, 32'd0);
`else
    chk("wait_busy", {31'b0, busy}, 32'd1);
    chk("wait_error", {31'b0, error}, 32'd0);
    chk("wait_probe_valid", {31'b0, probe_valid}, 32'd1);
`endif
    chk("silent_no_done", done_cnt - d0, 32'd0);
    chk("silent_result", {24'b0, result_w}, {24'b0, res_before});
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    run_search(8'sh33, 0, 1'b0, lat);
    chk("post_silent_error", {31'b0, error}, 32'd0);

    // Exhaustive sweep.
    for (int t = -128; t < 128; t++) run_search(8'(t), 0, 1'b0, lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slt_search.md
SLT_SEARCH -- requirements
Module: slt_search

Interface
REQ-001 Parameter: N, default 32, operand/result width in bits (two's complement).
REQ-002 Parameter: TIMEOUT, default 16, max cycles to wait for a comparator response (used only under REQ-030).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request a new search; sampled only in IDLE.
REQ-006 Port: probe  output  N  signed trial value presented to the external signed less-than comparator.
REQ-007 Port: probe_valid  output  1  probe is valid and held stable awaiting a response.
REQ-008 Port: resp_valid  input  1  comparator response valid this cycle.
REQ-009 Port: lt  input  1  comparator verdict, 1 = hidden target < probe (signed); meaningful only with resp_valid.
REQ-010 Port: result  output  N  recovered signed target value.
REQ-011 Port: done  output  1  one-cycle pulse when result updates.
REQ-012 Port: busy  output  1  high whenever state is not IDLE.
REQ-013 Port: error  output  1  sticky timeout flag (REQ-030); constant 0 without the macro.

Function
REQ-014 Block SHALL act as the initiator of a signed comparison: it recovers an unknown signed N-bit target by successive approximation, one bit per accepted response, MSB first.
REQ-015 Search SHALL run in offset-binary: accumulator acc (N bits), bit index i; trial = acc | (1<<i); probe = trial ^ (1<<(N-1)).
REQ-016 On an accepted response: lt=1 -> acc keeps bit i cleared; lt=0 -> acc sets bit i; then i decrements.
REQ-017 After bit 0 resolves, result SHALL load acc_final ^ (1<<(N-1)), registered.
REQ-018 States: IDLE, PROBE, DONE. IDLE->PROBE on start (acc=0, i=N-1); PROBE->PROBE on response with i>0; PROBE->DONE on response with i=0; DONE->IDLE unconditionally after one cycle.
REQ-019 probe_valid SHALL be 1 exactly in PROBE; probe SHALL not change while probe_valid=1 and resp_valid=0.
REQ-020 A response is accepted only in the cycle where probe_valid=1 and resp_valid=1; resp_valid outside PROBE is ignored.
REQ-021 done SHALL be 1 exactly in the DONE cycle; result SHALL hold its value until the next DONE.
REQ-022 Latency with resp_valid tied high: start sampled at edge k, probe_valid high cycles k+1..k+N, done at cycle k+N+1; next start accepted at k+N+2.
REQ-023 start while busy=1 SHALL be ignored (no restart, no queueing).
REQ-024 Boundaries: target -2^(N-1) -> every lt=1, result 0x80..0; target 2^(N-1)-1 -> every lt=0, result 0x7F..F; exact match (target==probe) counts as lt=0.
REQ-025 probe SHALL read 0 in IDLE and DONE.

Reset
REQ-026 rst=1 at any edge SHALL force IDLE regardless of state, including mid-search.
REQ-027 Reset values: probe=0, probe_valid=0, result=0, done=0, busy=0, error=0, acc=0, i=N-1.
REQ-028 A response arriving in the same cycle as rst SHALL be discarded.
REQ-029 start asserted in the rst cycle SHALL be ignored.

Configuration
REQ-030 Macro SLT_SEARCH_TIMEOUT_EN defined: a counter SHALL count consecutive PROBE cycles without resp_valid; reaching TIMEOUT SHALL set error=1, drop probe_valid, go to IDLE without done, leave result unchanged; error clears only on rst or next accepted start.
REQ-031 Macro undefined: no counter, PROBE waits indefinitely, error tied 0.

Verification (N=8, behavioural signed comparator model)
REQ-032 Target -3, resp_valid tied 1, start pulse -> probes 0x00,0xC0,0xE0,0xF0,0xF8,0xFC,0xFE,0xFD; done at cycle 9 after start; result=0xFD.
REQ-033 Targets 0x80 and 0x7F -> result 0x80 (all lt=1) and 0x7F (all lt=0); exhaustive sweep of all 256 targets matches.
REQ-034 Target 0x25, responder inserts 0-3 random wait cycles per probe -> probe stable during waits, result=0x25, exactly one done pulse.
REQ-035 rst asserted on 4th probe, then start with target 0x11 -> all outputs at reset values the cycle after rst; new search yields 0x11; extra start pulses while busy have no effect.
REQ-036 With SLT_SEARCH_TIMEOUT_EN, TIMEOUT=16, responder silent after 2nd probe -> error=1 after 16 waiting cycles, busy=0, no done, result unchanged; without macro busy stays 1 and error stays 0.
